ring_guard: RTL and testbench
=============================

Name: ring_guard

Overview:
- Synthesisable privilege-ring monitor that sits beside CPUTop, between the program counter, data memory and register file.
- Classifies each cycle as privileged (ring 0) or user, based on the PC.
- Drives the program and data memory offsets for virtual addressing.
- Checks jumps, data accesses and register selects against configurable ring-0 limits. On a violation it squashes the access, latches the fault cause and address, and halts the core until software or the bench clears the fault.
- Has a log-only mode for bring-up.

Parameters:
ADDR_W, 16, width of PC, jump target and data address
SEL_W, 5, register-select width
PC_LIMIT, 255, last privileged program address
ENTRY, 0, only legal user-to-ring-0 jump target
MEM_LIMIT, 63, last privileged data address
REG_LIMIT, 3, last privileged register index
CNT_W, 8, fault counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
pc  in  ADDR_W  current program counter
pc_valid  in  1  instruction executing this cycle
jump  in  1  jump taken this cycle
jump_target  in  ADDR_W  pre-offset jump destination
syscall_req  in  1  syscall register non-zero
mem_valid  in  1  data memory access this cycle
mem_addr  in  ADDR_W  pre-offset data address
rd_a_valid / rd_b_valid  in  1  register read port A/B used
rd_a_sel / rd_b_sel  in  SEL_W  read selects
wr_en  in  1  register write enable
wr_sel  in  SEL_W  write select
enforce  in  1  1 = halt on fault, 0 = log only
fault_clear  in  1  single-cycle pulse; leave FAULT
privileged  out  1  combinational: pc <= PC_LIMIT
prog_offset  out  ADDR_W  program memory offset
data_offset  out  ADDR_W  data memory offset
squash  out  1  combinational: suppress this cycle's write or jump
halt  out  1  registered; core must stall
fault_valid  out  1  unserviced fault present
fault_cause  out  3  latched cause
fault_addr  out  ADDR_W  latched offending address or select
fault_count  out  CNT_W  saturating count of all violations

Behaviour:
Reset (asynchronous): all registered outputs reset to 0; state RUN; prev_priv=1; prev_jump=0.

Privilege and offsets (combinational):
- priv = pc <= PC_LIMIT.
- prog_offset = 0 if priv, or if jump && syscall_req && jump_target==ENTRY; otherwise PC_LIMIT+1.
- data_offset = 0 if priv; otherwise MEM_LIMIT+1.

Violations: evaluated only when pc_valid && !priv && state==RUN. All checks use pre-offset values.
- JUMP: jump && jump_target<=PC_LIMIT && !(jump_target==ENTRY && syscall_req).
- MEM: mem_valid && mem_addr<=MEM_LIMIT.
- REG_WR: wr_en && wr_sel<=REG_LIMIT.
- REG_RD_A / REG_RD_B: valid && sel<=REG_LIMIT.
- FALLTHRU: prev_priv && !priv && !prev_jump. This check is evaluated even though priv is now 0; it catches kernel code running past PC_LIMIT without a jump.

Fault cause encoding and priority (highest first):
- 6 FALLTHRU, 1 JUMP, 2 MEM, 3 REG_WR, 4 REG_RD_A, 5 REG_RD_B; 0 = none.
- fault_addr per cause: FALLTHRU → pc; JUMP → jump_target; MEM → mem_addr; register causes → select zero-extended.

squash = any violation && enforce (same cycle, combinational).

State machine RUN/FAULT:
- RUN, violation: latch cause/addr, fault_valid<=1, fault_count+1 (saturates at all-ones). If enforce=1, go to FAULT; if enforce=0, stay in RUN.
- FAULT: halt=1 and no new checks. fault_clear → next state RUN, fault_valid<=0, halt<=0. fault_cause and fault_addr stay sticky until the next fault.
- fault_clear in RUN: clears fault_valid only.
- Violation and fault_clear in the same RUN cycle: the violation wins.

Latency: halt and fault_* are visible the cycle after the violating cycle.

prev_priv and prev_jump update only on pc_valid cycles.

Reset asserted mid-fault: returns to RUN immediately; the counter is cleared.

Decomposition:
- Package ring_guard_pkg holds:
  - the cause enum (NONE=0, JUMP=1, MEM=2, REG_WR=3, REG_RD_A=4, REG_RD_B=5, FALLTHRU=6);
  - the state enum (RUN, FAULT);
  - a helper function giving the offset for a limit (limit+1).
- One natural sub-module, ring_guard_check: a purely combinational violation detector plus priority encoder producing {hit, cause, addr}.
- The top level holds the state register, sticky latches and counter.

Test Plan:
- User jump: pc=300, jump=1, jump_target=10, syscall_req=0, enforce=1 → squash=1 that cycle; next cycle halt=1, fault_cause=1, fault_addr=10, fault_count=1.
- Syscall entry: pc=300, jump to 0 with syscall_req=1 → no fault; prog_offset=0 that cycle; the following cycle at pc=0 gives privileged=1 and data_offset=0.
- Memory and register priority: pc=300, mem_valid, mem_addr=20, and wr_en with wr_sel=2 in the same cycle → fault_cause=2, fault_addr=20. With pc=300 and only rd_b_sel=1 valid → cause=5, fault_addr=1.
- Fall-through: pc steps 255→256 with no jump → fault_cause=6, fault_addr=256. Then pulse fault_clear → halt=0 next cycle, fault_valid=0, cause stays 6.
- Log mode: enforce=0, CNT_W=2, five user mem_addr=0 violations → halt stays 0, squash=0, fault_count saturates at 3, fault_cause=2.
- Asynchronous reset in FAULT mid-cycle → halt, fault_valid and fault_count go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ring_guard_pkg.sv
// ring_guard_pkg: shared cause/state encodings and limit-to-offset helper
package ring_guard_pkg;
    typedef enum logic [2:0] {
        NONE     = 3'd0,
        JUMP     = 3'd1,
        MEM      = 3'd2,
        REG_WR   = 3'd3,
        REG_RD_A = 3'd4,
        REG_RD_B = 3'd5,
        FALLTHRU = 3'd6
    } cause_t;

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    function automatic int unsigned offset_of(input int unsigned limit);
        return limit + 1;
    endfunction
endpackage

// File: rtl/ring_guard_check.sv
// ring_guard_check: combinational ring-0 violation detector and priority encoder
module ring_guard_check
    import ring_guard_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned SEL_W     = 5,
    parameter int unsigned PC_LIMIT  = 255,
    parameter int unsigned ENTRY     = 0,
    parameter int unsigned MEM_LIMIT = 63,
    parameter int unsigned REG_LIMIT = 3
) (
    input  logic              active,
    input  logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              syscall_req,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              rd_a_valid,
    input  logic [SEL_W-1:0]  rd_a_sel,
    input  logic              rd_b_valid,
    input  logic [SEL_W-1:0]  rd_b_sel,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic              prev_priv,
    input  logic              prev_jump,
    output logic              hit,
    output cause_t            cause,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [ADDR_W-1:0] PC_LIM  = ADDR_W'(PC_LIMIT);
    localparam logic [ADDR_W-1:0] ENTRY_A = ADDR_W'(ENTRY);
    localparam logic [ADDR_W-1:0] MEM_LIM = ADDR_W'(MEM_LIMIT);
    localparam logic [SEL_W-1:0]  REG_LIM = SEL_W'(REG_LIMIT);

    logic v_fall, v_jump, v_mem, v_wr, v_ra, v_rb;

    assign v_fall = active && prev_priv && !prev_jump;
    assign v_jump = active && jump && jump_target <= PC_LIM && !(jump_target == ENTRY_A && syscall_req);
    assign v_mem  = active && mem_valid && mem_addr <= MEM_LIM;
    assign v_wr   = active && wr_en && wr_sel <= REG_LIM;
    assign v_ra   = active && rd_a_valid && rd_a_sel <= REG_LIM;
    assign v_rb   = active && rd_b_valid && rd_b_sel <= REG_LIM;

    always_comb begin
        cause = v_fall ? FALLTHRU : v_jump ? JUMP : v_mem ? MEM : v_wr ? REG_WR :
                v_ra ? REG_RD_A : v_rb ? REG_RD_B : NONE;
        addr  = v_fall ? pc : v_jump ? jump_target : v_mem ? mem_addr : v_wr ? ADDR_W'(wr_sel) :
                v_ra ? ADDR_W'(rd_a_sel) : v_rb ? ADDR_W'(rd_b_sel) : '0;
        hit   = cause != NONE;
    end
endmodule

// File: rtl/ring_guard.sv
// ring_guard: privilege-ring monitor with offsets, fault latching and halt control
module ring_guard
    import ring_guard_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned SEL_W     = 5,
    parameter int unsigned PC_LIMIT  = 255,
    parameter int unsigned ENTRY     = 0,
    parameter int unsigned MEM_LIMIT = 63,
    parameter int unsigned REG_LIMIT = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              syscall_req,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              rd_a_valid,
    input  logic              rd_b_valid,
    input  logic [SEL_W-1:0]  rd_a_sel,
    input  logic [SEL_W-1:0]  rd_b_sel,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic              enforce,
    input  logic              fault_clear,
    output logic              privileged,
    output logic [ADDR_W-1:0] prog_offset,
    output logic [ADDR_W-1:0] data_offset,
    output logic              squash,
    output logic              halt,
    output logic              fault_valid,
    output logic [2:0]        fault_cause,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [CNT_W-1:0]  fault_count
);
    localparam logic [ADDR_W-1:0] PC_LIM  = ADDR_W'(PC_LIMIT);
    localparam logic [ADDR_W-1:0] ENTRY_A = ADDR_W'(ENTRY);

    state_t            state, state_next;
    cause_t            hit_cause, cause_q;
    logic [ADDR_W-1:0] hit_addr;
    logic              hit, prev_priv, prev_jump;

    assign privileged  = pc <= PC_LIM;
    assign prog_offset = (privileged || (jump && syscall_req && jump_target == ENTRY_A)) ? '0 : ADDR_W'(offset_of(PC_LIMIT));
    assign data_offset = privileged ? '0 : ADDR_W'(offset_of(MEM_LIMIT));
    assign squash      = hit && enforce;
    assign halt        = state == FAULT;
    assign fault_cause = cause_q;

    ring_guard_check #(
        .ADDR_W(ADDR_W), .SEL_W(SEL_W), .PC_LIMIT(PC_LIMIT),
        .ENTRY(ENTRY), .MEM_LIMIT(MEM_LIMIT), .REG_LIMIT(REG_LIMIT)
    ) u_check (
        .active(pc_valid && !privileged && state == RUN),
        .pc(pc), .jump(jump), .jump_target(jump_target), .syscall_req(syscall_req),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .rd_a_valid(rd_a_valid), .rd_a_sel(rd_a_sel),
        .rd_b_valid(rd_b_valid), .rd_b_sel(rd_b_sel),
        .wr_en(wr_en), .wr_sel(wr_sel),
        .prev_priv(prev_priv), .prev_jump(prev_jump),
        .hit(hit), .cause(hit_cause), .addr(hit_addr)
    );

    always_comb begin
        state_next = state;
        if (state == RUN && squash)
            state_next = FAULT;
        else if (state == FAULT && fault_clear)
            state_next = RUN;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            fault_valid <= 1'b0;
            cause_q     <= NONE;
            fault_addr  <= '0;
            fault_count <= '0;
            prev_priv   <= 1'b1;
            prev_jump   <= 1'b0;
        end else begin
            state <= state_next;
            if (hit) begin
                fault_valid <= 1'b1;
                cause_q     <= hit_cause;
                fault_addr  <= hit_addr;
                if (!(&fault_count))
                    fault_count <= fault_count + 1'b1;
            end else if (fault_clear) begin
                fault_valid <= 1'b0;
            end
            if (pc_valid) begin
                prev_priv <= privileged;
                prev_jump <= jump;
            end
        end
    end
endmodule

// File: tb/tb_ring_guard.sv
// tb_ring_guard: table-driven and sequence checks for ring_guard
module tb_ring_guard;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc, jump_target, mem_addr;
    logic        pc_valid, jump, syscall_req, mem_valid, rd_a_valid, rd_b_valid, wr_en, enforce, fault_clear;
    logic [4:0]  rd_a_sel, rd_b_sel, wr_sel;

    logic        privileged, squash, halt, fault_valid;
    logic [15:0] prog_offset, data_offset, fault_addr;
    logic [2:0]  fault_cause;
    logic [7:0]  fault_count;

    logic        s_privileged, s_squash, s_halt, s_fault_valid;
    logic [15:0] s_prog_offset, s_data_offset, s_fault_addr;
    logic [2:0]  s_fault_cause;
    logic [1:0]  s_fault_count;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    ring_guard u_dut (
        .clock(clock), .reset(reset), .pc(pc), .pc_valid(pc_valid), .jump(jump),
        .jump_target(jump_target), .syscall_req(syscall_req), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .rd_a_valid(rd_a_valid), .rd_b_valid(rd_b_valid),
        .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .wr_en(wr_en), .wr_sel(wr_sel),
        .enforce(enforce), .fault_clear(fault_clear), .privileged(privileged),
        .prog_offset(prog_offset), .data_offset(data_offset), .squash(squash),
        .halt(halt), .fault_valid(fault_valid), .fault_cause(fault_cause),
        .fault_addr(fault_addr), .fault_count(fault_count)
    );

    ring_guard #(.CNT_W(2)) u_small (
        .clock(clock), .reset(reset), .pc(pc), .pc_valid(pc_valid), .jump(jump),
        .jump_target(jump_target), .syscall_req(syscall_req), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .rd_a_valid(rd_a_valid), .rd_b_valid(rd_b_valid),
        .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .wr_en(wr_en), .wr_sel(wr_sel),
        .enforce(enforce), .fault_clear(fault_clear), .privileged(s_privileged),
        .prog_offset(s_prog_offset), .data_offset(s_data_offset), .squash(s_squash),
        .halt(s_halt), .fault_valid(s_fault_valid), .fault_cause(s_fault_cause),
        .fault_addr(s_fault_addr), .fault_count(s_fault_count)
    );

    typedef struct {
        logic        pv;
        logic [15:0] pc;
        logic        j;
        logic [15:0] jt;
        logic        sys;
        logic        mv;
        logic [15:0] ma;
        logic        rav;
        logic [4:0]  ras;
        logic        rbv;
        logic [4:0]  rbs;
        logic        we;
        logic [4:0]  ws;
        logic        enf;
        logic        e_priv;
        logic [15:0] e_po;
        logic [15:0] e_do;
        logic        e_sq;
        logic        e_fv;
        logic [2:0]  e_cause;
        logic [15:0] e_addr;
        logic        e_halt;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        pc = 16'd0; pc_valid = 1'b0; jump = 1'b0; jump_target = 16'd0; syscall_req = 1'b0;
        mem_valid = 1'b0; mem_addr = 16'd0; rd_a_valid = 1'b0; rd_a_sel = 5'd0;
        rd_b_valid = 1'b0; rd_b_sel = 5'd0; wr_en = 1'b0; wr_sel = 5'd0;
        enforce = 1'b1; fault_clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle();
        reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    // kernel jumps out to user space so the next user cycle is not a fall-through
    task automatic preamble();
        idle();
        pc_valid = 1'b1; jump = 1'b1; jump_target = 16'd300;
        @(negedge clock);
    endtask

    task automatic apply(input vec_t v);
        idle();
        pc_valid = v.pv; pc = v.pc; jump = v.j; jump_target = v.jt; syscall_req = v.sys;
        mem_valid = v.mv; mem_addr = v.ma; rd_a_valid = v.rav; rd_a_sel = v.ras;
        rd_b_valid = v.rbv; rd_b_sel = v.rbs; wr_en = v.we; wr_sel = v.ws; enforce = v.enf;
    endtask

    initial begin
        vecs[0]  = '{1, 300, 1, 10,  0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 256, 64, 1, 1, 1, 10,  1};
        vecs[1]  = '{1, 300, 1, 0,   1, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 0,   64, 0, 0, 0, 0,   0};
        vecs[2]  = '{1, 300, 0, 0,   0, 1, 20, 0, 0, 0, 0, 1, 2,  1, 0, 256, 64, 1, 1, 2, 20,  1};
        vecs[3]  = '{1, 300, 0, 0,   0, 0, 0,  0, 0, 1, 1, 0, 0,  1, 0, 256, 64, 1, 1, 5, 1,   1};
        vecs[4]  = '{1, 300, 0, 0,   0, 0, 0,  1, 3, 1, 2, 0, 0,  1, 0, 256, 64, 1, 1, 4, 3,   1};
        vecs[5]  = '{1, 300, 0, 0,   0, 0, 0,  1, 2, 0, 0, 1, 4,  1, 0, 256, 64, 1, 1, 4, 2,   1};
        vecs[6]  = '{1, 300, 0, 0,   0, 1, 64, 0, 0, 0, 0, 0, 0,  1, 0, 256, 64, 0, 0, 0, 0,   0};
        vecs[7]  = '{1, 300, 0, 0,   0, 1, 63, 0, 0, 0, 0, 0, 0,  1, 0, 256, 64, 1, 1, 2, 63,  1};
        vecs[8]  = '{1, 300, 1, 255, 1, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 256, 64, 1, 1, 1, 255, 1};
        vecs[9]  = '{1, 300, 1, 256, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 256, 64, 0, 0, 0, 0,   0};
        vecs[10] = '{1, 300, 1, 0,   0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 0, 256, 64, 1, 1, 1, 0,   1};
        vecs[11] = '{1, 100, 1, 5,   0, 1, 0,  1, 0, 0, 0, 1, 0,  1, 1, 0,   0,  0, 0, 0, 0,   0};
        vecs[12] = '{1, 255, 0, 0,   0, 1, 0,  0, 0, 0, 0, 0, 0,  1, 1, 0,   0,  0, 0, 0, 0,   0};
        vecs[13] = '{1, 256, 0, 0,   0, 0, 0,  0, 0, 0, 0, 1, 3,  0, 0, 256, 64, 0, 1, 3, 3,   0};
        vecs[14] = '{0, 300, 0, 0,   0, 1, 0,  0, 0, 0, 0, 0, 0,  1, 0, 256, 64, 0, 0, 0, 0,   0};
        vecs[15] = '{1, 300, 0, 0,   0, 0, 0,  1, 4, 1, 5, 1, 31, 1, 0, 256, 64, 0, 0, 0, 0,   0};
        vecs[16] = '{1, 300, 1, 0,   1, 1, 10, 0, 0, 0, 0, 0, 0,  1, 0, 0,   64, 1, 1, 2, 10,  1};

        idle();
        reset = 1'b1;
        #12 reset = 1'b0;
        @(negedge clock);
        chk("reset_halt", int'(halt), 0);
        chk("reset_fault_valid", int'(fault_valid), 0);
        chk("reset_cause", int'(fault_cause), 0);
        chk("reset_count", int'(fault_count), 0);

        for (int i = 0; i < 17; i++) begin
            do_reset();
            preamble();
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d_priv", i), int'(privileged), int'(vecs[i].e_priv));
            chk($sformatf("v%0d_prog_offset", i), int'(prog_offset), int'(vecs[i].e_po));
            chk($sformatf("v%0d_data_offset", i), int'(data_offset), int'(vecs[i].e_do));
            chk($sformatf("v%0d_squash", i), int'(squash), int'(vecs[i].e_sq));
            @(negedge clock);
            chk($sformatf("v%0d_fault_valid", i), int'(fault_valid), int'(vecs[i].e_fv));
            chk($sformatf("v%0d_cause", i), int'(fault_cause), int'(vecs[i].e_cause));
            chk($sformatf("v%0d_addr", i), int'(fault_addr), int'(vecs[i].e_addr));
            chk($sformatf("v%0d_halt", i), int'(halt), int'(vecs[i].e_halt));
            chk($sformatf("v%0d_count", i), int'(fault_count), int'(vecs[i].e_fv));
        end

        // syscall entry followed by kernel code at the entry point
        do_reset();
        preamble();
        idle(); pc_valid = 1'b1; pc = 16'd300; jump = 1'b1; jump_target = 16'd0; syscall_req = 1'b1;
        @(negedge clock);
        idle(); pc_valid = 1'b1; pc = 16'd0;
        #1;
        chk("sys_priv", int'(privileged), 1);
        chk("sys_data_offset", int'(data_offset), 0);
        @(negedge clock);
        chk("sys_fault_valid", int'(fault_valid), 0);

        // fall-through from 255 to 256, then clear
        do_reset();
        idle(); pc_valid = 1'b1; pc = 16'd255;
        @(negedge clock);
        idle(); pc_valid = 1'b1; pc = 16'd256;
        #1 chk("fall_squash", int'(squash), 1);
        @(negedge clock);
        chk("fall_halt", int'(halt), 1);
        chk("fall_cause", int'(fault_cause), 6);
        chk("fall_addr", int'(fault_addr), 256);
        idle(); pc_valid = 1'b1; pc = 16'd300; mem_valid = 1'b1;
        #1 chk("fault_no_squash", int'(squash), 0);
        @(negedge clock);
        chk("fault_hold_halt", int'(halt), 1);
        chk("fault_no_recount", int'(fault_count), 1);
        idle(); fault_clear = 1'b1;
        @(negedge clock);
        idle();
        chk("clear_halt", int'(halt), 0);
        chk("clear_fault_valid", int'(fault_valid), 0);
        chk("clear_cause_sticky", int'(fault_cause), 6);
        chk("clear_addr_sticky", int'(fault_addr), 256);

        // log-only mode with counter saturation on the narrow instance
        do_reset();
        preamble();
        for (int k = 0; k < 5; k++) begin
            idle(); pc_valid = 1'b1; pc = 16'd300; mem_valid = 1'b1; enforce = 1'b0;
            #1 chk($sformatf("log_squash%0d", k), int'(squash), 0);
            @(negedge clock);
            chk($sformatf("log_halt%0d", k), int'(halt), 0);
        end
        chk("log_count8", int'(fault_count), 5);
        chk("log_count2_sat", int'(s_fault_count), 3);
        chk("log_cause", int'(fault_cause), 2);
        chk("log_fault_valid", int'(fault_valid), 1);
        idle(); pc_valid = 1'b1; pc = 16'd300; mem_valid = 1'b1; enforce = 1'b0; fault_clear = 1'b1;
        @(negedge clock);
        chk("log_clear_loses", int'(fault_valid), 1);
        chk("log_count8_6", int'(fault_count), 6);
        idle(); enforce = 1'b0; fault_clear = 1'b1;
        @(negedge clock);
        chk("log_clear", int'(fault_valid), 0);
        chk("log_clear_cause", int'(fault_cause), 2);

        // asynchronous reset while halted
        do_reset();
        preamble();
        idle(); pc_valid = 1'b1; pc = 16'd300; jump = 1'b1; jump_target = 16'd10;
        @(negedge clock);
        idle();
        chk("pre_areset_halt", int'(halt), 1);
        #2 reset = 1'b1;
        #1;
        chk("areset_halt", int'(halt), 0);
        chk("areset_fault_valid", int'(fault_valid), 0);
        chk("areset_count", int'(fault_count), 0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
